// File: rtl/dmni_mem_arbiter.sv
// dmni_mem_arbiter: burst-granular arbiter sharing the DMNI local-memory port between N_REQ DMA requesters.
// Define DMNI_MEM_ARB_FIXED_PRIO_EN to select lowest-index-wins fixed priority instead of round-robin.
module dmni_mem_arbiter #(
    parameter int N_REQ     = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ-1:0]       last_i,
    input  logic [N_REQ-1:0][3:0]  we_i,
    input  logic [N_REQ-1:0][31:0] addr_i,
    input  logic [N_REQ-1:0][31:0] data_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [N_REQ-1:0]       rvalid_o,
    output logic [31:0]            rdata_o,
    output logic [3:0]             mem_we_o,
    output logic [31:0]            mem_addr_o,
    output logic [31:0]            mem_data_o,
    input  logic [31:0]            mem_data_i
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BCW = $clog2(MAX_BURST);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);
    localparam logic [IDW-1:0] TOP_ID    = IDW'(N_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t         state_r, state_s;
    logic [IDW-1:0] owner_r, owner_s;
    logic [IDW-1:0] rr_ptr_r, rr_ptr_s;
    logic [IDW-1:0] rd_id_r, rd_id_s;
    logic [IDW-1:0] pick_s;
    logic [IDW-1:0] next_ptr_s;
    logic [BCW-1:0] beat_cnt_r, beat_cnt_s;
    logic           rd_pend_r, rd_pend_s;
    logic [N_REQ-1:0] gnt_s;
    logic [3:0]     mem_we_s;
    logic [31:0]    mem_addr_s;
    logic [31:0]    mem_data_s;

`ifdef DMNI_MEM_ARB_FIXED_PRIO_EN
    // Requester selection: lowest requesting index wins.
    always_comb begin
        pick_s = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_i[IDW'(k)]) begin
                pick_s = IDW'(k);
            end else begin
                pick_s = pick_s;
            end
        end
    end

    assign next_ptr_s = '0;
`else
    // Requester selection: first requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        logic [IDW:0]   sum;
        logic [IDW-1:0] cand;
        pick_s = '0;
        sum    = '0;
        cand   = '0;
        // Scan from the farthest offset down so the nearest requester is written last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_r} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(N_REQ)) begin
                sum = sum - (IDW+1)'(N_REQ);
            end else begin
                sum = sum;
            end
            cand = sum[IDW-1:0];
            if (req_i[cand]) begin
                pick_s = cand;
            end else begin
                pick_s = pick_s;
            end
        end
    end

    assign next_ptr_s = (owner_r == TOP_ID) ? '0 : owner_r + IDW'(1);
`endif

    // Next-state, burst accounting and memory-port mux.
    always_comb begin
        state_s    = state_r;
        owner_s    = owner_r;
        rr_ptr_s   = rr_ptr_r;
        beat_cnt_s = beat_cnt_r;
        rd_pend_s  = 1'b0;
        rd_id_s    = rd_id_r;
        gnt_s      = '0;
        mem_we_s   = 4'b0000;
        mem_addr_s = 32'h0000_0000;
        mem_data_s = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                if (|req_i) begin
                    owner_s    = pick_s;
                    beat_cnt_s = '0;
                    state_s    = ST_BURST;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (req_i[owner_r]) begin
                    gnt_s[owner_r] = 1'b1;
                    mem_we_s       = we_i[owner_r];
                    mem_addr_s     = addr_i[owner_r];
                    mem_data_s     = data_i[owner_r];
                    if (we_i[owner_r] == 4'b0000) begin
                        rd_pend_s = 1'b1;
                        rd_id_s   = owner_r;
                    end else begin
                        rd_pend_s = 1'b0;
                    end
                    // The MAX_BURST-1 check keeps beat_cnt from ever wrapping.
                    if (last_i[owner_r] || (beat_cnt_r == LAST_BEAT)) begin
                        state_s    = ST_IDLE;
                        rr_ptr_s   = next_ptr_s;
                        beat_cnt_s = '0;
                    end else begin
                        beat_cnt_s = beat_cnt_r + BCW'(1);
                    end
                end else begin
                    state_s  = ST_IDLE;
                    rr_ptr_s = next_ptr_s;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Read return one cycle after the granted read, regardless of arbiter state.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = 32'h0000_0000;
        if (rd_pend_r) begin
            rvalid_o[rd_id_r] = 1'b1;
            rdata_o           = mem_data_i;
        end else begin
            rdata_o           = 32'h0000_0000;
        end
    end

    assign gnt_o      = gnt_s;
    assign mem_we_o   = mem_we_s;
    assign mem_addr_o = mem_addr_s;
    assign mem_data_o = mem_data_s;

    // State registers; reset drops any read still in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            owner_r    <= '0;
            rr_ptr_r   <= '0;
            beat_cnt_r <= '0;
            rd_pend_r  <= 1'b0;
            rd_id_r    <= '0;
        end else begin
            state_r    <= state_s;
            owner_r    <= owner_s;
            rr_ptr_r   <= rr_ptr_s;
            beat_cnt_r <= beat_cnt_s;
            rd_pend_r  <= rd_pend_s;
            rd_id_r    <= rd_id_s;
        end
    end

endmodule

// File: tb/tb_dmni_mem_arbiter.sv
// tb_dmni_mem_arbiter: vector table, directed burst sequences and a randomized run against a reference model.
// Build with DMNI_MEM_ARB_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_dmni_mem_arbiter;

    localparam int N  = 2;
    localparam int MB = 16;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]       req, last;
    logic [N-1:0][3:0]  we;
    logic [N-1:0][31:0] addr, data;
    logic [N-1:0]       gnt, rvalid;
    logic [31:0]        rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]         mem_we;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: transaction-level view of the port
    bit m_busy, m_rd;
    int m_owner, m_ptr, m_beats, m_rd_id;

    logic [N-1:0] a_gnt, a_rv;
    logic [31:0]  a_rd, a_ma, a_md;
    logic [3:0]   a_we;

    typedef struct {
        logic        rst;
        logic [1:0]  req, last;
        logic [3:0]  we0, we1;
        logic [31:0] a0, a1, d0, d1, md;
        logic [1:0]  g, rv;
        logic [31:0] rd;
        logic [3:0]  mwe;
        logic [31:0] ma, mdo;
    } vec_t;

    vec_t tv [10];
    logic [1:0] t5_req  [8];
    logic [1:0] t5_last [8];
    logic [1:0] t5_exp  [8];

    dmni_mem_arbiter #(.N_REQ(N), .MAX_BURST(MB)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .last_i(last), .we_i(we),
        .addr_i(addr), .data_i(data), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_data_i(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] g, input logic [N-1:0] rv,
                         input logic [31:0] rd, input logic [3:0] mwe, input logic [31:0] ma,
                         input logic [31:0] md);
        n_checks++;
        if (a_gnt !== g || a_rv !== rv || a_rd !== rd || a_we !== mwe || a_ma !== ma || a_md !== md) begin
            n_fail++;
            $display("FAIL %s @%0t: got gnt=%b rvalid=%b rdata=%h we=%b addr=%h wdata=%h, want gnt=%b rvalid=%b rdata=%h we=%b addr=%h wdata=%h",
                     name, $time, a_gnt, a_rv, a_rd, a_we, a_ma, a_md, g, rv, rd, mwe, ma, md);
        end
    endtask

    task automatic check_gnt(input string name, input logic [N-1:0] g);
        logic [3:0]  mwe;
        logic [31:0] ma, md;
        mwe = 4'h0; ma = 32'h0; md = 32'h0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                mwe = we[i]; ma = addr[i]; md = data[i];
            end
        end
        check(name, g, '0, 32'h0, mwe, ma, md);
    endtask

    task automatic check_model();
        logic [N-1:0] g, rv;
        logic [31:0]  rd, ma, md;
        logic [3:0]   mwe;
        g = '0; rv = '0; rd = 32'h0; ma = 32'h0; md = 32'h0; mwe = 4'h0;
        if (m_busy && req[m_owner]) begin
            g[m_owner] = 1'b1; mwe = we[m_owner]; ma = addr[m_owner]; md = data[m_owner];
        end
        if (m_rd) begin
            rv[m_rd_id] = 1'b1; rd = mem_rdata;
        end
        check("model", g, rv, rd, mwe, ma, md);
    endtask

    task automatic model_update();
        int c, nxt;
        bit found;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0; m_rd = 0; m_rd_id = 0;
        end else begin
            m_rd = 0;
`ifdef DMNI_MEM_ARB_FIXED_PRIO_EN
            nxt = 0;
`else
            nxt = (m_owner + 1) % N;
`endif
            if (!m_busy) begin
                if (req != '0) begin
                    found = 0;
                    for (int k = 0; k < N; k++) begin
`ifdef DMNI_MEM_ARB_FIXED_PRIO_EN
                        c = k;
`else
                        c = (m_ptr + k) % N;
`endif
                        if (!found && req[c]) begin
                            m_owner = c; found = 1;
                        end
                    end
                    m_busy = 1; m_beats = 0;
                end
            end else if (!req[m_owner]) begin
                m_busy = 0; m_ptr = nxt;
            end else begin
                m_beats++;
                if (we[m_owner] == 4'h0) begin
                    m_rd = 1; m_rd_id = m_owner;
                end
                if (last[m_owner] || m_beats == MB) begin
                    m_busy = 0; m_ptr = nxt;
                end
            end
        end
    endtask

    task automatic step(input bit use_model);
        @(negedge clk);
        a_gnt = gnt; a_rv = rvalid; a_rd = rdata; a_we = mem_we; a_ma = mem_addr; a_md = mem_wdata;
        if (use_model) check_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        tv[0] = '{1'b1, 2'b11, 2'b00, 4'h0, 4'h0, 32'h0,   32'h0,   32'h0,        32'h0,        32'hA000_0000, 2'b00, 2'b00, 32'h0,         4'h0, 32'h0,   32'h0};
        tv[1] = '{1'b0, 2'b11, 2'b00, 4'h0, 4'h0, 32'h0,   32'h0,   32'h0,        32'h0,        32'hA000_0001, 2'b00, 2'b00, 32'h0,         4'h0, 32'h0,   32'h0};
        tv[2] = '{1'b0, 2'b01, 2'b00, 4'h0, 4'h0, 32'h100, 32'h0,   32'h1111_1111, 32'h0,       32'hA000_0002, 2'b01, 2'b00, 32'h0,         4'h0, 32'h100, 32'h1111_1111};
        tv[3] = '{1'b0, 2'b01, 2'b00, 4'h0, 4'h0, 32'h104, 32'h0,   32'h1111_1111, 32'h0,       32'hA000_0003, 2'b01, 2'b01, 32'hA000_0003, 4'h0, 32'h104, 32'h1111_1111};
        tv[4] = '{1'b0, 2'b01, 2'b00, 4'h0, 4'h0, 32'h108, 32'h0,   32'h1111_1111, 32'h0,       32'hA000_0004, 2'b01, 2'b01, 32'hA000_0004, 4'h0, 32'h108, 32'h1111_1111};
        tv[5] = '{1'b0, 2'b01, 2'b01, 4'h0, 4'h0, 32'h10C, 32'h0,   32'h1111_1111, 32'h0,       32'hA000_0005, 2'b01, 2'b01, 32'hA000_0005, 4'h0, 32'h10C, 32'h1111_1111};
        tv[6] = '{1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0,   32'h0,   32'h0,        32'h0,        32'hA000_0006, 2'b00, 2'b01, 32'hA000_0006, 4'h0, 32'h0,   32'h0};
        tv[7] = '{1'b0, 2'b10, 2'b10, 4'h0, 4'h3, 32'h0,   32'h200, 32'h0,        32'hDEAD_BEEF, 32'hA000_0007, 2'b00, 2'b00, 32'h0,         4'h0, 32'h0,   32'h0};
        tv[8] = '{1'b0, 2'b10, 2'b10, 4'h0, 4'h3, 32'h0,   32'h200, 32'h0,        32'hDEAD_BEEF, 32'hA000_0008, 2'b10, 2'b00, 32'h0,         4'h3, 32'h200, 32'hDEAD_BEEF};
        tv[9] = '{1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0,   32'h0,   32'h0,        32'h0,        32'hA000_0009, 2'b00, 2'b00, 32'h0,         4'h0, 32'h0,   32'h0};

        t5_req  = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b01};
        t5_last = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01};
`ifdef DMNI_MEM_ARB_FIXED_PRIO_EN
        t5_exp  = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
`else
        t5_exp  = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01};
`endif

        rst = 1'b1; req = '0; last = '0; we = '0; addr = '0; data = '0; mem_rdata = 32'h0;
        step(1'b0);

        // reset, 4-beat read burst, single-beat write
        for (int i = 0; i < 10; i++) begin
            rst = tv[i].rst; req = tv[i].req; last = tv[i].last;
            we[0] = tv[i].we0; we[1] = tv[i].we1; addr[0] = tv[i].a0; addr[1] = tv[i].a1;
            data[0] = tv[i].d0; data[1] = tv[i].d1; mem_rdata = tv[i].md;
            step(1'b0);
            check($sformatf("vec%0d", i), tv[i].g, tv[i].rv, tv[i].rd, tv[i].mwe, tv[i].ma, tv[i].mdo);
        end

        // continuous requests from both: MAX_BURST-long bursts with one idle gap
        req = 2'b11; last = 2'b00; we[0] = 4'hF; we[1] = 4'hF;
        addr[0] = 32'h300; addr[1] = 32'h400; data[0] = 32'hA0A0_A0A0; data[1] = 32'hB1B1_B1B1;
        for (int c = 0; c < 3 * (MB + 1); c++) begin
            logic [1:0] eg;
            step(1'b0);
            if (c % (MB + 1) == 0) eg = 2'b00;
`ifdef DMNI_MEM_ARB_FIXED_PRIO_EN
            else eg = 2'b01;
`else
            else eg = ((c / (MB + 1)) % 2 == 0) ? 2'b01 : 2'b10;
`endif
            check_gnt($sformatf("burst_c%0d", c), eg);
        end

        // owner drops request mid-burst while the other waits
        for (int c = 0; c < 8; c++) begin
            req = t5_req[c]; last = t5_last[c];
            step(1'b0);
            check_gnt($sformatf("drop_c%0d", c), t5_exp[c]);
        end

        // reset right after a granted read: its rvalid must never appear
        req = 2'b01; last = 2'b00; we[0] = 4'h0; addr[0] = 32'h500; mem_rdata = 32'h5555_AAAA;
        step(1'b0);
        check_gnt("rst_d0", 2'b00);
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0; req = 2'b00;
        step(1'b0);
        check("rst_d2", 2'b00, 2'b00, 32'h0, 4'h0, 32'h0, 32'h0);
        step(1'b0);
        check("rst_d3", 2'b00, 2'b00, 32'h0, 4'h0, 32'h0, 32'h0);

        // randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
                last[i] = ($urandom_range(0, 31) == 0);
                we[i]   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                addr[i] = $urandom;
                data[i] = $urandom;
            end
            mem_rdata = $urandom;
            step(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
